tri_bbox_scanner: RTL and testbench

Upstream feeder for the triangle point-weight stage. Accepts one `triangle` per valid/ready handshake, computes its screen-clamped bounding box, then walks every pixel of that box in raster order. It presents a `point` plus the held `triangle` to the weight-calculation stage over a valid/ready stream and flags the final pixel.

---
 rtl/tri_bbox_scanner.sv | 153 +++++++++++++++
 tb/tb_tri_bbox_scanner.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/tri_bbox_scanner.sv
// Triangle bounding-box scanner: accepts a triangle, clamps its box to the screen and streams every pixel in raster order.
// Packing: point = {x[31:0], y[31:0]}, triangle = {a, b, c}. Optional back-face culling: TRI_BBOX_SCANNER_BACKFACE_CULL_EN.
module tri_bbox_scanner #(
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [191:0] in_tri_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   output logic [191:0] out_tri_o,
   output logic [63:0]  out_point_o,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic         out_last_o,
   output logic         busy_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_BBOX, ST_SCAN} state_e;

   localparam logic signed [31:0] X_LIM = 32'(SCREEN_W - 1);
   localparam logic signed [31:0] Y_LIM = 32'(SCREEN_H - 1);

   function automatic logic signed [31:0] min2(input logic signed [31:0] p, input logic signed [31:0] q);
      return (p < q) ? p : q;
   endfunction

   function automatic logic signed [31:0] max2(input logic signed [31:0] p, input logic signed [31:0] q);
      return (p > q) ? p : q;
   endfunction

   state_e              state_q, state_d;
   logic [191:0]        tri_q, tri_d;
   logic signed [31:0]  cur_x_q, cur_x_d, cur_y_q, cur_y_d;
   logic signed [31:0]  xmin_q, xmin_d, xmax_q, xmax_d, ymax_q, ymax_d;
   logic                last_q, last_d;

   logic signed [31:0]  ax, ay, bx, by, cx, cy;
   logic signed [31:0]  bb_xmin, bb_xmax, bb_ymin, bb_ymax;
   logic signed [31:0]  nx, ny;
   logic                box_empty, cull;
`ifdef TRI_BBOX_SCANNER_BACKFACE_CULL_EN
   logic signed [65:0]  edge_val;
`endif

   assign ax = tri_q[191:160];
   assign ay = tri_q[159:128];
   assign bx = tri_q[127:96];
   assign by = tri_q[95:64];
   assign cx = tri_q[63:32];
   assign cy = tri_q[31:0];

   assign bb_xmin   = max2(min2(ax, min2(bx, cx)), 32'sd0);
   assign bb_xmax   = min2(max2(ax, max2(bx, cx)), X_LIM);
   assign bb_ymin   = max2(min2(ay, min2(by, cy)), 32'sd0);
   assign bb_ymax   = min2(max2(ay, max2(by, cy)), Y_LIM);
   assign box_empty = (bb_xmin > bb_xmax) || (bb_ymin > bb_ymax);

   // Wide products so extreme coordinates cannot flip the sign of the edge function.
`ifdef TRI_BBOX_SCANNER_BACKFACE_CULL_EN
   assign edge_val = (66'(bx) - 66'(ax)) * (66'(cy) - 66'(ay))
                   - (66'(by) - 66'(ay)) * (66'(cx) - 66'(ax));
   assign cull     = (edge_val <= 66'sd0);
`else
   assign cull     = 1'b0;
`endif

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
      state_d = state_q;
      tri_d   = tri_q;
      cur_x_d = cur_x_q;
      cur_y_d = cur_y_q;
      xmin_d  = xmin_q;
      xmax_d  = xmax_q;
      ymax_d  = ymax_q;
      last_d  = last_q;
      nx      = cur_x_q;
      ny      = cur_y_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid_i) begin
               tri_d   = in_tri_i;
               state_d = ST_BBOX;
            end
         end
         ST_BBOX: begin
            if (box_empty || cull) begin
               state_d = ST_IDLE;
            end else begin
               cur_x_d = bb_xmin;
               cur_y_d = bb_ymin;
               xmin_d  = bb_xmin;
               xmax_d  = bb_xmax;
               ymax_d  = bb_ymax;
               last_d  = (bb_xmin == bb_xmax) && (bb_ymin == bb_ymax);
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (out_ready_i) begin
               if (last_q) begin
                  last_d  = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  if (cur_x_q == xmax_q) begin
                     nx = xmin_q;
                     ny = cur_y_q + 32'sd1;
                  end else begin
                     nx = cur_x_q + 32'sd1;
                  end
                  cur_x_d = nx;
                  cur_y_d = ny;
                  last_d  = (nx == xmax_q) && (ny == ymax_q);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         tri_q   <= '0;
         cur_x_q <= '0;
         cur_y_q <= '0;
         xmin_q  <= '0;
         xmax_q  <= '0;
         ymax_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from the pre-edge values.
         state_q <= state_d;
         tri_q   <= tri_d;
         cur_x_q <= cur_x_d;
         cur_y_q <= cur_y_d;
         xmin_q  <= xmin_d;
         xmax_q  <= xmax_d;
         ymax_q  <= ymax_d;
         last_q  <= last_d;
      end
   end

   assign in_ready_o  = (state_q == ST_IDLE);
   assign busy_o      = (state_q != ST_IDLE);
   assign out_valid_o = (state_q == ST_SCAN);
   assign out_last_o  = last_q;
   assign out_tri_o   = tri_q;
   assign out_point_o = {cur_x_q, cur_y_q};

endmodule

// File: tb/tb_tri_bbox_scanner.sv
// Directed bench for tri_bbox_scanner: raster order, stalls, clamping, off-screen drop, reset abort, optional culling.
module tb_tri_bbox_scanner;

   logic         clk = 1'b0;
   logic         rst;
   logic [191:0] in_tri;
   logic         in_valid;
   logic         in_ready;
   logic [191:0] out_tri;
   logic [63:0]  out_point;
   logic         out_valid;
   logic         out_ready;
   logic         out_last;
   logic         busy;

   int n_vec  = 0;
   int n_miss = 0;
   int ex[64];
   int ey[64];
   logic [191:0] cur_tri;

   tri_bbox_scanner #(.SCREEN_W(640), .SCREEN_H(480)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_tri_i    (in_tri),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .out_tri_o   (out_tri),
      .out_point_o (out_point),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_last_o  (out_last),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [191:0] mk_tri(input int ax, input int ay, input int bx, input int by,
                                           input int cx, input int cy);
      return {ax, ay, bx, by, cx, cy};
   endfunction

   // Expected raster sequence over an inclusive box.
   function automatic int fill_box(input int x0, input int x1, input int y0, input int y1);
      int n = 0;
      for (int y = y0; y <= y1; y++)
         for (int x = x0; x <= x1; x++) begin
            ex[n] = x;
            ey[n] = y;
            n++;
         end
      return n;
   endfunction

   // Returns at the falling edge after the accepting clock edge.
   task automatic accept(input logic [191:0] t);
      check("in_ready_before_accept", in_ready, 1);
      cur_tri  = t;
      in_tri   = t;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_tri   = '0;
      check("busy_in_bbox", busy, 1);
      check("in_ready_in_bbox", in_ready, 0);
      check("out_valid_in_bbox", out_valid, 0);
   endtask

   task automatic scan(input int npts, input bit stall);
      int idx = 0;
      int cyc = 0;
      @(negedge clk);
      check("first_valid_two_after_accept", out_valid, 1);
      check("out_tri", out_tri, cur_tri);
      while (idx < npts && cyc < 500) begin
         out_ready = stall ? (cyc % 3 == 0) : 1'b1;
         check("valid", out_valid, 1);
         check("point", out_point, {ex[idx], ey[idx]});
         check("last", out_last, (idx == npts - 1));
         check("in_ready_busy", in_ready, 0);
         @(posedge clk);
         if (out_ready) idx++;
         @(negedge clk);
         cyc++;
      end
      check("scan_timeout", (cyc < 500), 1);
      out_ready = 1'b0;
      check("valid_after_last", out_valid, 0);
      check("in_ready_after_last", in_ready, 1);
      check("busy_after_last", busy, 0);
   endtask

   task automatic expect_drop(input logic [191:0] t);
      accept(t);
      @(negedge clk);
      check("drop_no_valid", out_valid, 0);
      check("drop_in_ready", in_ready, 1);
      check("drop_not_busy", busy, 0);
      @(negedge clk);
      check("drop_still_idle", out_valid, 0);
   endtask

   initial begin
      int n;
      rst       = 1'b1;
      in_tri    = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_busy", busy, 0);
      check("rst_out_point", out_point, 0);
      check("rst_out_tri", out_tri, 0);
      rst = 1'b0;
      @(negedge clk);

      // Basic 4x2 box with continuous ready.
      n = fill_box(2, 5, 3, 4);
      accept(mk_tri(2, 3, 5, 3, 2, 4));
      scan(n, 1'b0);

      // Same triangle with stalls; back-to-back accept right after the last transfer.
      accept(mk_tri(2, 3, 5, 3, 2, 4));
      scan(n, 1'b1);

      // Negative coordinates clamp to the screen origin.
      n = fill_box(0, 1, 0, 0);
      accept(mk_tri(-3, -2, 1, -2, -3, 0));
      scan(n, 1'b0);

      // Entirely right of the screen.
      expect_drop(mk_tri(700, 10, 710, 10, 700, 20));

      // Single-pixel box at the far screen corner.
      n = fill_box(639, 639, 479, 479);
      accept(mk_tri(639, 479, 800, 479, 639, 600));
      scan(n, 1'b0);

      // Reset while the third point is presented.
      accept(mk_tri(2, 3, 5, 3, 2, 4));
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_mid_point3", out_point, {32'd4, 32'd3});
      out_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("abort_out_valid", out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_in_ready", in_ready, 1);
      rst = 1'b0;
      @(negedge clk);
      n = fill_box(0, 1, 0, 0);
      accept(mk_tri(-3, -2, 1, -2, -3, 0));
      scan(n, 1'b0);

`ifdef TRI_BBOX_SCANNER_BACKFACE_CULL_EN
      expect_drop(mk_tri(0, 0, 0, 4, 4, 0));
      expect_drop(mk_tri(0, 0, 1, 1, 2, 2));
      n = fill_box(0, 4, 0, 4);
      accept(mk_tri(0, 0, 4, 0, 0, 4));
      scan(n, 1'b0);
`else
      // Without culling, both windings scan the full 5x5 box.
      n = fill_box(0, 4, 0, 4);
      accept(mk_tri(0, 0, 0, 4, 4, 0));
      scan(n, 1'b0);
      accept(mk_tri(0, 0, 4, 0, 0, 4));
      scan(n, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
